// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes and datapath selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    DST_RT  = 2'd0,
    DST_RD  = 2'd1,
    DST_R31 = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALU = 2'd0,
    M2R_MEM = 2'd1,
    M2R_PC4 = 2'd2
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  // jr shares the R-type opcode and is told apart by funct
  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory request/acknowledge bus between the controller (master) and memory (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mem_watchdog.sv
// Counts consecutive stalled memory cycles and pulses timeout_c on the cycle the limit is reached.
module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  input  logic clr,
  output logic timeout_c
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] cnt;
  logic          stall;

  assign stall = req && !ack;
  // An ack in the limit cycle clears stall, so the late ack wins over the fault
  assign timeout_c = stall && (cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!stall || clr || timeout_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory watchdog and retired-instruction counter.
// Build option: define MULTICYCLE_JAL_EN to decode jal (opcode 0x03) instead of faulting on it.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_if.master      mem,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      alu_zero,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic                      reg_write,
  output logic [1:0]                pc_src,
  output logic [1:0]                reg_dst,
  output logic [1:0]                mem_to_reg,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                alu_op,
  output logic [3:0]                state,
  output logic [CNT_W-1:0]          instr_count,
  output logic                      err
);

  state_t state_q;
  state_t state_d;
  logic   timeout_c;
  logic   state_change;
  logic   retire;

  assign state_change = (state_d != state_q);
  assign retire       = (state_d == S_FETCH) && (state_q != S_FETCH);
  assign state        = state_q;
  assign err          = (state_q == S_ERROR);

  mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .req       (mem.mem_req),
    .ack       (mem.mem_ack),
    .clr       (state_change),
    .timeout_c (timeout_c)
  );

  // Next state and control decode; everything is Moore except the ack/zero/jal-qualified enables
  always_comb begin
    state_d     = state_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    pc_src      = PC_PLUS4;
    reg_dst     = DST_RT;
    mem_to_reg  = M2R_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = ALU_ADD;

    unique case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'd1;
        if (mem.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:     state_d = is_jr(opcode, funct) ? S_JUMP : S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       state_d = S_JUMP;
`else
          OP_JAL:       state_d = S_ERROR;
`endif
          default:      state_d = S_ERROR;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_WB_I;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack)    state_d = S_WB_MEM;
        else if (timeout_c) state_d = S_ERROR;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack)    state_d = S_FETCH;
        else if (timeout_c) state_d = S_ERROR;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        state_d   = S_FETCH;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MEM;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_BRANCH;
        pc_write  = alu_zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = is_jr(opcode, funct) ? PC_RS : PC_JUMP;
`ifdef MULTICYCLE_JAL_EN
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = DST_R31;
          mem_to_reg = M2R_PC4;
        end
`endif
        state_d = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // State register and retirement counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases plus a random instruction stream
// checked cycle by cycle against a per-instruction-class path model.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int          TO    = 15;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JR, K_JAL, K_ILL} kind_t;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             ir_write, pc_write, reg_write;
  logic [1:0]       pc_src, reg_dst, mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             err;

  int tests = 0;
  int failed = 0;
  int exp_count = 0;

  multicycle_control_if mem_bus ();

  multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mem_bus),
    .opcode      (opcode),
    .funct       (funct),
    .alu_zero    (alu_zero),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .pc_src      (pc_src),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .state       (state),
    .instr_count (instr_count),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Instruction class straight from the opcode table
  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h08) ? K_JR : K_R;
      6'h08:   return K_I;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
`ifdef MULTICYCLE_JAL_EN
      6'h03:   return K_JAL;
`endif
      default: return K_ILL;
    endcase
  endfunction

  // Drive mem_ack for the current cycle on the falling edge, then settle before checking
  task automatic tick(input logic ack);
    @(negedge clk);
    mem_bus.mem_ack = ack;
    #1;
  endtask

  // Non-memory state: ack is noise and must be ignored
  task automatic step(input state_t s);
    tick(1'($urandom_range(0, 1)));
    chk("state", state, s);
    chk("idle_mem_req", mem_bus.mem_req, 0);
    chk("idle_ir_write", ir_write, 0);
  endtask

  // Memory phase: 'waits' cycles without ack, then ack; TO stalled cycles end in ERROR
  task automatic wait_phase(input state_t s, input int waits, input logic we, output logic ok);
    ok = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      if (i == TO) begin
        tick(1'b0);
        chk("timeout_state", state, S_ERROR);
        chk("timeout_err", err, 1);
        chk("timeout_req", mem_bus.mem_req, 0);
        ok = 1'b0;
        return;
      end
      tick(i == waits);
      chk("mem_state", state, s);
      chk("mem_req", mem_bus.mem_req, 1);
      chk("mem_we", mem_bus.mem_we, we);
      chk("iord", mem_bus.iord, (s != S_FETCH));
      chk("err_clear", err, 0);
      if (s == S_FETCH) begin
        if (i == 0) chk("instr_count", instr_count, exp_count);
        chk("ir_write", ir_write, (i == waits));
        chk("fetch_pc_write", pc_write, (i == waits));
        chk("fetch_pc_src", pc_src, 0);
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                           input int fw, input int mw);
    kind_t k;
    logic  ok;
    opcode   = op;
    funct    = fn;
    alu_zero = zero;
    k        = classify(op, fn);
    wait_phase(S_FETCH, fw, 1'b0, ok);
    if (!ok) return;
    step(S_DECODE);
    case (k)
      K_R: begin
        step(S_EXEC_R);
        step(S_WB_R);
        chk("wbr_reg_write", reg_write, 1);
        chk("wbr_reg_dst", reg_dst, 1);
        chk("wbr_m2r", mem_to_reg, 0);
      end
      K_I: begin
        step(S_EXEC_I);
        step(S_WB_I);
        chk("wbi_reg_write", reg_write, 1);
        chk("wbi_reg_dst", reg_dst, 0);
        chk("wbi_m2r", mem_to_reg, 0);
      end
      K_LW: begin
        step(S_ADDR);
        wait_phase(S_MEM_RD, mw, 1'b0, ok);
        if (ok) begin
          step(S_WB_MEM);
          chk("wbm_reg_write", reg_write, 1);
          chk("wbm_reg_dst", reg_dst, 0);
          chk("wbm_m2r", mem_to_reg, 1);
        end
      end
      K_SW: begin
        step(S_ADDR);
        wait_phase(S_MEM_WR, mw, 1'b1, ok);
      end
      K_BEQ: begin
        step(S_BRANCH);
        chk("beq_pc_write", pc_write, zero);
        chk("beq_pc_src", pc_src, 1);
      end
      K_J, K_JR, K_JAL: begin
        step(S_JUMP);
        chk("jump_pc_write", pc_write, 1);
        chk("jump_pc_src", pc_src, (k == K_JR) ? 3 : 2);
        chk("jump_reg_write", reg_write, (k == K_JAL));
        chk("jump_r31_dst", (reg_dst == 2'd2), (k == K_JAL));
        chk("jump_pc4_wb", (mem_to_reg == 2'd2), (k == K_JAL));
      end
      default: begin
        step(S_ERROR);
        chk("ill_err", err, 1);
        step(S_ERROR);
        chk("ill_sticky_err", err, 1);
        chk("ill_pc_write", pc_write, 0);
        chk("ill_reg_write", reg_write, 0);
        ok = 1'b0;
      end
    endcase
    if (ok) exp_count = (exp_count + 1) % (1 << CNT_W);
  endtask

  // Reset pulse raised and checked between clock edges, so it must act asynchronously
  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_state", state, S_FETCH);
    chk("rst_count", instr_count, 0);
    chk("rst_err", err, 0);
    #1 reset = 1'b0;
    exp_count = 0;
  endtask

  initial begin
    int   sel;
    logic [5:0] rop, rfn;
    reset           = 1'b1;
    opcode          = 6'h00;
    funct           = 6'h20;
    alu_zero        = 1'b0;
    mem_bus.mem_ack = 1'b0;
    #1;
    chk("por_state", state, S_FETCH);
    chk("por_count", instr_count, 0);
    pulse_reset();

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 late acks
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'h00, 6'h20, 1'b0, TO - 1, 0); // ack exactly on the limit cycle
    run_instr(6'h2B, 6'h00, 1'b0, 1, 2);   // sw
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);   // addi
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // jr

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 6));
      rfn = 6'($urandom_range(0, 63));
      case (sel)
        0:       rop = 6'h00;
        1:       rop = 6'h08;
        2:       rop = 6'h23;
        3:       rop = 6'h2B;
        4:       rop = 6'h04;
        5:       rop = 6'h02;
        default: begin rop = 6'h00; rfn = 6'h08; end
      endcase
      if (sel == 0 && rfn == 6'h08) rfn = 6'h20;
      run_instr(rop, rfn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    // Reset while a store is stalled in MEM_WR
    opcode = 6'h2B;
    funct  = 6'h00;
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    opcode = 6'h2B;
    tick(1'b1);
    chk("pre_fetch", state, S_FETCH);
    step(S_DECODE);
    step(S_ADDR);
    tick(1'b0);
    chk("memwr_state", state, S_MEM_WR);
    tick(1'b0);
    chk("memwr_we", mem_bus.mem_we, 1);
    #1 reset = 1'b1;
    #1;
    chk("midreq_rst_state", state, S_FETCH);
    chk("midreq_rst_count", instr_count, 0);
    chk("midreq_rst_req", mem_bus.mem_req, 1);
    opcode          = 6'h02;
    mem_bus.mem_ack = 1'b1;
    #1 reset = 1'b0;
    exp_count = 0;
    @(negedge clk);
    #1;
    chk("post_rst_decode", state, S_DECODE);
    step(S_JUMP);
    exp_count = 1;

    // Drive the 4-bit counter through a full wrap with back-to-back jumps
    for (int n = 0; n < 16; n++) run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);

    run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // jal: JUMP or ERROR by build
    pulse_reset();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal opcode
    pulse_reset();
    run_instr(6'h00, 6'h20, 1'b0, TO, 0);  // fetch ack withheld to the limit
    pulse_reset();
    run_instr(6'h23, 6'h00, 1'b0, 0, TO);  // load ack withheld to the limit
    pulse_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    tick(1'b0);
    chk("final_state", state, S_FETCH);
    chk("final_count", instr_count, exp_count);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
